// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer.
// Each raw button level is synchronized into the clk_in domain. It is then sampled
// on every rising edge of the slow clk_debounce square wave, which is treated as
// data and never as a clock. A level change is accepted after STABLE_SAMPLES equal
// consecutive samples.
//
// Ports:
//   clk_in        system clock, all state on its rising edge
//   rst_n         asynchronous active-low reset
//   clk_debounce  slow sampling square wave (data, registered in clk_in domain)
//   btn_raw       raw asynchronous button levels, 1 = pressed
//   btn_level     debounced level per button
//   btn_press     one-cycle pulse when a 0->1 change is accepted
//   btn_release   one-cycle pulse when a 1->0 change is accepted
module button_debouncer #(
  parameter int unsigned NUM_BTN        = 4,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               clk_debounce,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // 4 bits covers the largest allowed STABLE_SAMPLES of 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] btn_sync_q;
  logic               db_q;
  logic               tick_c;

  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;

  // One-cycle strobe on each rising edge of the sampling wave.
  assign tick_c = clk_debounce & ~db_q;

  // Per-button next-state and sample-count logic; everything holds between ticks.
  always_comb begin
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_c) begin
        unique case (state_q[i])
          RELEASED: begin
            if (btn_sync_q[i]) begin
              state_d[i] = PRESS_WAIT;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          PRESS_WAIT: begin
            if (!btn_sync_q[i]) begin
              state_d[i] = RELEASED;
              cnt_d[i]   = '0;
            end else if ((cnt_q[i] + CNT_W'(1)) == CNT_W'(STABLE_SAMPLES)) begin
              state_d[i] = PRESSED;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!btn_sync_q[i]) begin
              state_d[i] = RELEASE_WAIT;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            if (btn_sync_q[i]) begin
              state_d[i] = PRESSED;
              cnt_d[i]   = '0;
            end else if ((cnt_q[i] + CNT_W'(1)) == CNT_W'(STABLE_SAMPLES)) begin
              state_d[i] = RELEASED;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // The level stays high while a release is still being qualified.
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
    end
  end

  // Synchronizers, tick edge detector, FSM state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      btn_sync_q <= '0;
      db_q       <= 1'b0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      btn_sync_q <= sync1_q;
      db_q       <= clk_debounce;
      level_q    <= level_d;
      // Pulses line up with the first cycle of the new level.
      press_q    <= level_d & ~level_q;
      release_q  <= ~level_d & level_q;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer.
// The reference model tracks, per button, the accepted level and the length of
// the current run of samples that disagree with it.
module tb_button_debouncer;

  localparam int unsigned NB = 4;
  localparam int unsigned SS = 3;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          clk_debounce;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  always #5 clk_in = ~clk_in;

  button_debouncer #(.NUM_BTN(NB), .STABLE_SAMPLES(SS)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .clk_debounce (clk_debounce),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [NB-1:0] m_h1, m_h2;      // raw levels seen one and two edges ago
  logic          m_cdp;           // sampling wave at the previous edge
  logic [NB-1:0] m_acc;           // accepted level
  logic [NB-1:0] m_press, m_rel;  // expected pulses after this edge
  int            m_run [NB];      // consecutive samples differing from m_acc
  int            phase   = 0;
  bit            cd_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_cdp = 1'b0;
    m_acc = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < int'(NB); i++) m_run[i] = 0;
  endtask

  // One clk_in edge: advance the model, compare, then update the sampling wave.
  task automatic step();
    logic tick;
    @(posedge clk_in);
    tick    = clk_debounce & ~m_cdp;
    m_press = '0;
    m_rel   = '0;
    if (tick) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (m_h2[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(SS)) begin
            m_acc[i] = m_h2[i];
            m_run[i] = 0;
            if (m_h2[i]) m_press[i] = 1'b1;
            else         m_rel[i]   = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_h2  = m_h1;
    m_h1  = btn_raw;
    m_cdp = clk_debounce;
    #1;
    chk("level",   32'(btn_level),               32'(m_acc));
    chk("press",   32'(btn_press),               32'(m_press));
    chk("release", 32'(btn_release),             32'(m_rel));
    chk("excl",    32'(btn_press & btn_release), 32'd0);
    if (!cd_hold) begin
      phase        = (phase + 1) % 16;
      clk_debounce = (phase >= 8);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset: outputs must clear immediately and stay clear.
  task automatic do_reset(input logic [NB-1:0] raw);
    btn_raw = raw;
    rst_n   = 1'b0;
    #1;
    chk("rst_level",   32'(btn_level),   32'd0);
    chk("rst_press",   32'(btn_press),   32'd0);
    chk("rst_release", 32'(btn_release), 32'd0);
    @(posedge clk_in);
    #1;
    chk("rst_hold_level", 32'(btn_level), 32'd0);
    chk("rst_hold_press", 32'(btn_press), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
    phase        = 0;
    cd_hold      = 1'b0;
    clk_debounce = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    btn_raw      = '0;
    clk_debounce = 1'b0;
    model_reset();
    #2;
    // All buttons held through reset; nothing may pulse before the third tick.
    do_reset(4'b1111);
    run(60);
    btn_raw = '0;      run(80);
    // Single button press.
    btn_raw = 4'b0001; run(80);
    // Bounce on button 1 spanning about two ticks.
    btn_raw = 4'b0011; run(22);
    btn_raw = 4'b0001; run(60);
    // Release button 0 with a glitch near the second low tick.
    btn_raw = 4'b0000; run(18);
    btn_raw = 4'b0001; run(6);
    btn_raw = 4'b0000; run(80);
    // Two buttons rising together.
    btn_raw = 4'b1100; run(70);
    btn_raw = 4'b0000; run(70);
    // Sampling wave frozen high: only one tick.
    cd_hold = 1'b1; clk_debounce = 1'b1;
    btn_raw = 4'b0010; run(100);
    cd_hold = 1'b0;
    btn_raw = 4'b0000; run(70);
    // Reset in the middle of a press qualification.
    btn_raw = 4'b0010; run(28);
    do_reset(4'b0010);
    run(70);
    // Random phase.
    for (int r = 0; r < 60; r++) begin
      btn_raw = NB'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        cd_hold      = ~cd_hold;
        clk_debounce = cd_hold ? 1'($urandom) : clk_debounce;
      end
      if ($urandom_range(0, 15) == 0) do_reset(NB'($urandom));
      run(int'($urandom_range(1, 60)));
    end
    cd_hold = 1'b0;
    btn_raw = '0;
    run(80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4, giving the number of independent button channels (range 1..8).
REQ-002 The block SHALL have parameter STABLE_SAMPLES, default 3, giving the consecutive equal samples needed to accept a level change (range 2..15).
REQ-003 Port clk_in, input, 1, is the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk_debounce, input, 1, is the slow sampling square wave; it is a register output in the clk_in domain and SHALL be used as data only, never as a clock.
REQ-006 Port btn_raw, input, NUM_BTN, carries the raw asynchronous button levels, with 1 meaning pressed.
REQ-007 Port btn_level, output, NUM_BTN, carries the debounced registered level per button.
REQ-008 Port btn_press, output, NUM_BTN, carries a one-clk_in-cycle pulse per button on an accepted 0->1 change.
REQ-009 Port btn_release, output, NUM_BTN, carries a one-clk_in-cycle pulse per button on an accepted 1->0 change.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer (btn_sync) before any use.
REQ-011 The block SHALL register clk_debounce into db_q and define tick = clk_debounce & ~db_q (combinational), so tick is high for exactly one clk_in cycle per clk_debounce rising edge.
REQ-012 If clk_debounce is held high or low, the block SHALL produce no further ticks.
REQ-013 Each button SHALL have an independent 4-state FSM (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) plus a 4-bit sample counter cnt.
REQ-014 On cycles without tick, FSM state, cnt and btn_level SHALL hold.
REQ-015 On a tick in RELEASED: btn_sync=1 -> PRESS_WAIT with cnt=1; btn_sync=0 -> stay in RELEASED.
REQ-016 On a tick in PRESS_WAIT: btn_sync=0 -> RELEASED with cnt=0; btn_sync=1 and cnt+1==STABLE_SAMPLES -> PRESSED with cnt=0; btn_sync=1 otherwise -> cnt+1.
REQ-017 On a tick in PRESSED: btn_sync=0 -> RELEASE_WAIT with cnt=1; btn_sync=1 -> stay in PRESSED.
REQ-018 On a tick in RELEASE_WAIT: btn_sync=1 -> PRESSED with cnt=0; btn_sync=0 and cnt+1==STABLE_SAMPLES -> RELEASED with cnt=0; btn_sync=0 otherwise -> cnt+1.
REQ-019 btn_level SHALL be 1 exactly when the FSM is in PRESSED or RELEASE_WAIT, registered so that it changes on the clk_in edge that ends the accepting tick cycle.
REQ-020 btn_press (btn_release) SHALL be high for exactly the one cycle in which btn_level first shows 1 (0), and SHALL never be high simultaneously with each other for the same button.
REQ-021 Acceptance latency SHALL be exactly STABLE_SAMPLES ticks from the first tick that samples the new stable level, plus 1 clk_in cycle.
REQ-022 Synchronizer latency SHALL be 2 clk_in cycles, and a raw level is visible to a tick only if it is stable 2 cycles before that tick.
REQ-023 Channels SHALL not interact; simultaneous acceptances on several buttons SHALL pulse in the same cycle.
REQ-024 The cnt bit width SHALL hold STABLE_SAMPLES without overflow; cnt SHALL never exceed STABLE_SAMPLES-1.

Reset
REQ-025 While rst_n=0, the block SHALL force all FSMs to RELEASED, cnt=0, db_q=0, synchronizer flops=0, and btn_level, btn_press and btn_release to 0, immediately (asynchronously).
REQ-026 After rst_n deasserts, a button held high SHALL still need STABLE_SAMPLES full ticks before it is accepted, and no pulse SHALL be produced by reset itself.
REQ-027 Reset asserted mid PRESS_WAIT or RELEASE_WAIT SHALL discard the partial count.

Verification
REQ-028 Reset with btn_raw=4'b1111 -> btn_level=btn_press=btn_release=0 during reset; after release, no press pulse before the 3rd tick.
REQ-029 Bench drives clk_debounce with period 16 cycles and holds btn_raw[0]=1 -> btn_level[0]=1 and btn_press[0] pulses 1 cycle after the 3rd tick; other bits stay 0.
REQ-030 Bounce: btn_raw[1] high across 2 ticks, then low -> btn_level[1] stays 0 and no btn_press[1] occurs.
REQ-031 Release btn 0 after acceptance -> btn_release[0] pulses once 1 cycle after the 3rd low tick; a glitch high at the 2nd low tick restarts the count.
REQ-032 btn_raw[3:2] rise together -> btn_press[3:2]=2'b11 in the same cycle.
REQ-033 Hold clk_debounce high for 100 cycles -> exactly one tick; pulse rst_n low during PRESS_WAIT -> outputs 0 and the count restarts.
